// File: rtl/mandel_pkg.sv
// mandel_pkg
// Shared definitions for the Mandelbrot dispatch path:
//   - dispatch_state_t : frame sequencing states (IDLE, RUN, DRAIN, DONE)
//   - WORD_W           : pixel word width {x_pix, y_pix, x_fix, y_fix}
//   - N_ENG_DEFAULT    : engine count, taken from the NUM_PROC macro
`ifndef NUM_PROC
`define NUM_PROC 8
`endif

package mandel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dispatch_state_t;

  localparam int WORD_W = 83;

  localparam int N_ENG_DEFAULT = `NUM_PROC;

endpackage

// File: rtl/mandel_dispatch_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search begins at the requester
// after ptr (wrapping modulo N) and picks the first active request.
// Ports:
//   req   in  N      request vector
//   ptr   in  PTR_W  index of the most recent winner
//   grant out N      one-hot grant (all zero when no request)
//   idx   out PTR_W  binary index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int N     = 8,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx
);

  int   w_j;
  logic w_found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_j     = 0;
    // Offsets 1..N visit every requester once, ptr itself last.
    for (int k = 1; k <= N; k++) begin
      w_j = (int'(ptr) + k) % N;
      if (!w_found && req[w_j]) begin
        w_found    = 1'b1;
        grant[w_j] = 1'b1;
        idx        = PTR_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/mandel_dispatch.sv
// mandel_dispatch
// Round-robin dispatcher from the pixel coordinate generator to a pool of
// Mandelbrot iteration engines. Each accepted word is sent to exactly one
// idle engine via a registered one-hot latch strobe; the frame is sequenced
// IDLE -> RUN -> DRAIN -> DONE -> IDLE.
// Optional feature macro: MANDEL_DISPATCH_STATS_EN (adds stall_cycles).
// Ports:
//   cclk, creset          clock, async active-high reset
//   start                 frame start pulse (honoured in IDLE only)
//   gen_valid/last/word   generator handshake, last-pixel flag, pixel word
//   gen_ready             word accepted this cycle when gen_valid is high
//   cdones                per-engine idle flags
//   latch_en/eng_addr     one-hot strobe and index of the dispatched engine
//   eng_word              registered copy of the accepted word
//   busy, frame_done      frame in progress / one-cycle completion pulse
//   stall_cycles          (stats build) RUN cycles stalled with gen_valid high
module mandel_dispatch
  import mandel_pkg::*;
#(
  parameter int N_ENG  = mandel_pkg::N_ENG_DEFAULT,
  parameter int ADDR_W = 4,
  parameter int WORD_W = mandel_pkg::WORD_W
) (
  input  logic              cclk,
  input  logic              creset,
  input  logic              start,
  input  logic              gen_valid,
  input  logic              gen_last,
  input  logic [WORD_W-1:0] gen_word,
  output logic              gen_ready,
  input  logic [N_ENG-1:0]  cdones,
  output logic [N_ENG-1:0]  latch_en,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [WORD_W-1:0] eng_word,
  output logic              busy,
`ifdef MANDEL_DISPATCH_STATS_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              frame_done
);

  dispatch_state_t   r_state;
  dispatch_state_t   w_state_next;
  logic [N_ENG-1:0]  r_claimed;
  logic [ADDR_W-1:0] r_rr_ptr;
  logic [N_ENG-1:0]  r_latch_en;
  logic [ADDR_W-1:0] r_eng_addr;
  logic [WORD_W-1:0] r_eng_word;

  logic [N_ENG-1:0]  w_eligible;
  logic [N_ENG-1:0]  w_grant;
  logic [ADDR_W-1:0] w_grant_idx;
  logic              w_accept;
  logic              w_drained;

  // An engine whose done flag has not yet dropped after dispatch still
  // reads idle; the claimed bit masks it until that low sample arrives.
  assign w_eligible = cdones & ~r_claimed;
  assign gen_ready  = (r_state == RUN) && (|w_eligible);
  assign w_accept   = gen_valid && gen_ready;
  assign w_drained  = (r_claimed == '0) && (&cdones);

  rr_arbiter #(
    .N     (N_ENG),
    .PTR_W (ADDR_W)
  ) u_rr_arbiter (
    .req   (w_eligible),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_grant_idx)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_accept && gen_last) w_state_next = DRAIN;
      DRAIN:   if (w_drained) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge cclk or posedge creset) begin
    if (creset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Claimed bookkeeping: a low done flag clears the bit, but a dispatch in
  // the same cycle re-sets it (set wins). The pointer starts at the last
  // engine so the first grant after reset goes to engine 0.
  always_ff @(posedge cclk or posedge creset) begin
    if (creset) begin
      r_claimed <= '0;
      r_rr_ptr  <= ADDR_W'(N_ENG - 1);
    end else begin
      r_claimed <= (r_claimed & cdones) | (w_accept ? w_grant : '0);
      if (w_accept) r_rr_ptr <= w_grant_idx;
    end
  end

  // Dispatch stage: strobe lasts one cycle, address and word hold until
  // the next accept.
  always_ff @(posedge cclk or posedge creset) begin
    if (creset) begin
      r_latch_en <= '0;
      r_eng_addr <= '0;
      r_eng_word <= '0;
    end else begin
      r_latch_en <= w_accept ? w_grant : '0;
      if (w_accept) begin
        r_eng_addr <= w_grant_idx;
        r_eng_word <= gen_word;
      end
    end
  end

  assign latch_en   = r_latch_en;
  assign eng_addr   = r_eng_addr;
  assign eng_word   = r_eng_word;
  assign busy       = (r_state == RUN) || (r_state == DRAIN);
  assign frame_done = (r_state == DONE);

`ifdef MANDEL_DISPATCH_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge cclk or posedge creset) begin
    if (creset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && gen_valid && !gen_ready &&
                 (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mandel_dispatch.sv
// tb_mandel_dispatch
// Directed bench for mandel_dispatch with four engines. Inputs change 1 ns
// after the rising edge; outputs are read at that same point.
module tb_mandel_dispatch;

  localparam int NE = 4;
  localparam int AW = 2;
  localparam int WW = 83;

  logic          cclk = 1'b0;
  logic          creset;
  logic          start;
  logic          gen_valid;
  logic          gen_last;
  logic [WW-1:0] gen_word;
  logic          gen_ready;
  logic [NE-1:0] cdones;
  logic [NE-1:0] latch_en;
  logic [AW-1:0] eng_addr;
  logic [WW-1:0] eng_word;
  logic          busy;
  logic          frame_done;
`ifdef MANDEL_DISPATCH_STATS_EN
  logic [31:0]   stall_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 cclk = ~cclk;

  mandel_dispatch #(
    .N_ENG  (NE),
    .ADDR_W (AW),
    .WORD_W (WW)
  ) dut (
    .cclk         (cclk),
    .creset       (creset),
    .start        (start),
    .gen_valid    (gen_valid),
    .gen_last     (gen_last),
    .gen_word     (gen_word),
    .gen_ready    (gen_ready),
    .cdones       (cdones),
    .latch_en     (latch_en),
    .eng_addr     (eng_addr),
    .eng_word     (eng_word),
    .busy         (busy),
`ifdef MANDEL_DISPATCH_STATS_EN
    .stall_cycles (stall_cycles),
`endif
    .frame_done   (frame_done)
  );

  function automatic logic [WW-1:0] word(input int k);
    return WW'(64'hA5A5_0000_0000_0000) + WW'(k);
  endfunction

  task automatic tick;
    @(posedge cclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    creset = 1'b1; start = 1'b0; gen_valid = 1'b0; gen_last = 1'b0;
    gen_word = '0; cdones = '1;
    tick; tick;
    chk("rst_ready",  128'(gen_ready), 128'(0));
    chk("rst_latch",  128'(latch_en), 128'(0));
    chk("rst_addr",   128'(eng_addr), 128'(0));
    chk("rst_word",   128'(eng_word), 128'(0));
    chk("rst_busy",   128'(busy), 128'(0));
    chk("rst_fdone",  128'(frame_done), 128'(0));
    creset = 1'b0;
    tick;

    // Frame 1: four back-to-back grants in round-robin order
    start = 1'b1; tick; start = 1'b0;
    chk("f1_busy",  128'(busy), 128'(1));
    chk("f1_ready", 128'(gen_ready), 128'(1));
    gen_valid = 1'b1; gen_word = word(0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rr_latch", 128'(latch_en), 128'(1 << k));
      chk("rr_addr",  128'(eng_addr), 128'(k));
      chk("rr_word",  128'(eng_word), 128'(word(k)));
      gen_word = word(k + 1);
    end
    chk("full_ready", 128'(gen_ready), 128'(0));
    tick;
    chk("full_latch", 128'(latch_en), 128'(0));
    chk("full_hold",  128'(eng_word), 128'(word(3)));
    chk("full_ready2", 128'(gen_ready), 128'(0));
    cdones = 4'b1101; tick;
    chk("low_ready", 128'(gen_ready), 128'(0));
    cdones = 4'b1111; #1;
    chk("rise_ready", 128'(gen_ready), 128'(1));
    tick;
    chk("re1_latch", 128'(latch_en), 128'(4'b0010));
    chk("re1_addr",  128'(eng_addr), 128'(1));
    chk("re1_word",  128'(eng_word), 128'(word(4)));
    gen_valid = 1'b0;

    // Done-lag: engine 2 keeps its done flag high one extra cycle
    cdones = 4'b0000; tick;
    cdones = 4'b1111; gen_valid = 1'b1; gen_word = word(5); tick;
    chk("lag_latch", 128'(latch_en), 128'(4'b0100));
    chk("lag_addr",  128'(eng_addr), 128'(2));
    cdones = 4'b0100; gen_word = word(6); #1;
    chk("lag_ready0", 128'(gen_ready), 128'(0));
    tick;
    chk("lag_nolatch", 128'(latch_en), 128'(0));
    chk("lag_ready1",  128'(gen_ready), 128'(0));
    cdones = 4'b0000; tick;
    chk("lag_nolatch2", 128'(latch_en), 128'(0));
    cdones = 4'b0100; #1;
    chk("lag_ready2", 128'(gen_ready), 128'(1));
    tick;
    chk("lag_regrant", 128'(latch_en), 128'(4'b0100));
    chk("lag_word",    128'(eng_word), 128'(word(6)));

    // Last word of frame 1, start pulse during DRAIN
    cdones = 4'b1111; gen_word = word(7); gen_last = 1'b1; tick;
    chk("last_latch", 128'(latch_en), 128'(4'b1000));
    chk("drain_ready", 128'(gen_ready), 128'(0));
    chk("drain_busy",  128'(busy), 128'(1));
    gen_valid = 1'b0; gen_last = 1'b0; cdones = 4'b0011; start = 1'b1; tick;
    start = 1'b0;
    chk("drain_fd0",   128'(frame_done), 128'(0));
    chk("drain_busy2", 128'(busy), 128'(1));
    cdones = 4'b1111; tick;
    chk("f1_done", 128'(frame_done), 128'(1));
    tick;
    chk("f1_done_off", 128'(frame_done), 128'(0));
    chk("f1_idle",     128'(busy), 128'(0));

    // Frame 2: three words, start pulse in RUN, staggered engine returns
    start = 1'b1; tick; start = 1'b0;
    gen_valid = 1'b1; gen_word = word(8); start = 1'b1; tick; start = 1'b0;
    chk("f2_latch0", 128'(latch_en), 128'(4'b0001));
    chk("f2_busy",   128'(busy), 128'(1));
    gen_word = word(9); tick;
    chk("f2_latch1", 128'(latch_en), 128'(4'b0010));
    gen_word = word(10); gen_last = 1'b1; tick;
    chk("f2_latch2", 128'(latch_en), 128'(4'b0100));
    chk("f2_drain_ready", 128'(gen_ready), 128'(0));
    gen_valid = 1'b0; gen_last = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cdones = {1'b1, (c >= 13), (c >= 7), (c >= 3)};
      start  = (c == 5);
      tick;
      chk("f2_fdone", 128'(frame_done), 128'(c == 13));
      if (frame_done) pulses++;
    end
    start = 1'b0;
    chk("f2_pulses", 128'(pulses), 128'(1));
    chk("f2_idle",   128'(busy), 128'(0));

    // Frame 3: reset mid-RUN with engines 1 and 2 claimed
    cdones = 4'b0110; start = 1'b1; tick; start = 1'b0;
    gen_valid = 1'b1; gen_word = word(11); tick;
    chk("f3_latch1", 128'(latch_en), 128'(4'b0010));
    gen_word = word(12); tick;
    chk("f3_latch2", 128'(latch_en), 128'(4'b0100));
    gen_word = word(13);
    creset = 1'b1; #1;
    chk("mrst_latch", 128'(latch_en), 128'(0));
    chk("mrst_addr",  128'(eng_addr), 128'(0));
    chk("mrst_word",  128'(eng_word), 128'(0));
    chk("mrst_busy",  128'(busy), 128'(0));
    chk("mrst_ready", 128'(gen_ready), 128'(0));
    chk("mrst_fdone", 128'(frame_done), 128'(0));
    tick;
    creset = 1'b0; gen_valid = 1'b0; cdones = 4'b1111;
    start = 1'b1; tick; start = 1'b0;
    gen_valid = 1'b1; gen_last = 1'b1; gen_word = word(14); tick;
    chk("f4_first_latch", 128'(latch_en), 128'(4'b0001));
    chk("f4_first_addr",  128'(eng_addr), 128'(0));
    gen_valid = 1'b0; gen_last = 1'b0; cdones = 4'b1110; tick;
    cdones = 4'b1111; tick;
    chk("f4_done", 128'(frame_done), 128'(1));
    tick;
    chk("f4_idle", 128'(busy), 128'(0));

`ifdef MANDEL_DISPATCH_STATS_EN
    // Single usable engine held busy for seven cycles with a word waiting
    cdones = 4'b0001; start = 1'b1; tick; start = 1'b0;
    chk("st_clear", 128'(stall_cycles), 128'(0));
    gen_valid = 1'b1; gen_word = word(15); tick;
    chk("st_latch", 128'(latch_en), 128'(4'b0001));
    cdones = 4'b0000;
    repeat (7) tick;
    cdones = 4'b0001; gen_last = 1'b1; tick;
    gen_valid = 1'b0; gen_last = 1'b0; cdones = 4'b0000; tick;
    cdones = 4'b1111; tick;
    chk("st_done",  128'(frame_done), 128'(1));
    chk("st_count", 128'(stall_cycles), 128'(7));
    tick;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mandel_dispatch.md
# mandel_dispatch

Round-robin dispatcher between the coordinate generator and the pool of Mandelbrot iteration engines. Each generated pixel word is accepted over a valid/ready handshake and sent to exactly one idle engine using a registered one-hot latch strobe. The block sequences each frame from start to drain: it accepts words until the generator flags the last pixel, then waits for every engine to finish before signalling frame completion.

## Interface
- N_ENG, default 8: number of engines; must match `NUM_PROC.
- ADDR_W, default 4: engine address width; 2**ADDR_W >= N_ENG.
- WORD_W, default 83: pixel word width ({x_pix, y_pix, x_fix, y_fix}).

Ports (clock and reset first):
- cclk  in  1  single clock; all state changes on the rising edge.
- creset  in  1  reset, asynchronous and active-high; clears all state.
- start  in  1  one-cycle pulse that begins a frame; ignored unless state is IDLE.
- gen_valid  in  1  generator holds a valid pixel word.
- gen_last  in  1  qualifies gen_valid: the word is the final pixel of the frame.
- gen_word  in  WORD_W  pixel word from the generator.
- gen_ready  out  1  dispatcher accepts the word this cycle.
- cdones  in  N_ENG  per-engine idle flag (1 = finished/idle).
- latch_en  out  N_ENG  registered one-hot strobe that loads eng_word into the engine.
- eng_addr  out  ADDR_W  index of the engine strobed this cycle.
- eng_word  out  WORD_W  registered copy of the accepted gen_word.
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse when a frame has fully drained.

## Operation
- States:
  - IDLE: start moves to RUN.
  - RUN: an accept with gen_last=1 moves to DRAIN.
  - DRAIN: moves to DONE once claimed==0 and cdones all ones.
  - DONE: moves to IDLE after one cycle, with frame_done=1.
- Eligibility: eligible[j] = cdones[j] & ~claimed[j].
  - claimed[j] is set on dispatch to j.
  - claimed[j] is cleared on the first cycle cdones[j] is sampled 0 after dispatch.
  - Purpose: covers the engine's one-cycle done-flag lag, so no engine is double-booked.
- gen_ready = (state==RUN) & |eligible. This is combinational from registered state and inputs.
- Accept = gen_valid & gen_ready.
- Grant: round-robin. Search starts at rr_ptr+1 mod N_ENG and takes the first eligible engine. On accept, rr_ptr takes the granted index.
- Simultaneous dispatch to j and cdones[j]=0 in the same cycle: the set takes priority and the clear waits for the next low sample.
- Engines never report done at the same time as a dispatch to themselves. If cdones[j] never falls after dispatch, claimed[j] stays set.
- start during RUN, DRAIN or DONE is ignored.
- gen_valid outside RUN is ignored; gen_ready=0 there.
- creset mid-frame:
  - Returns to IDLE and clears claimed, rr_ptr (to N_ENG-1, so the first grant goes to engine 0) and all outputs.
  - Engines already dispatched are not aborted.

## Timing
- Reset values: gen_ready=0, latch_en=0, eng_addr=0, eng_word=0, busy=0, frame_done=0, state IDLE.
- Accept in cycle t: latch_en, eng_addr and eng_word are valid in cycle t+1, for exactly one cycle. eng_word holds its value until the next accept.
- Throughput: one word per cycle while any engine is eligible.
- start at t: busy=1 from t+1.
- DRAIN exit condition true at t: frame_done=1 at t+1 (DONE), then busy=0 and IDLE at t+2.
- A frame with zero accepts cannot occur. The generator always supplies at least one word, flagged last.

## Configuration
- MANDEL_DISPATCH_STATS_EN defined:
  - Adds output stall_cycles, 32 bits.
  - Counts RUN cycles where gen_valid=1 and gen_ready=0.
  - Clears on start and saturates at 2**32-1.
  - Value holds after frame_done until the next start.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package mandel_pkg:
  - State enum (IDLE, RUN, DRAIN, DONE).
  - WORD_W constant, 83.
  - NUM_PROC-derived N_ENG default.
- One sub-module, rr_arbiter: parameter N; inputs req[N-1:0] and ptr; outputs a combinational one-hot grant and its binary index. It is reusable for result-collection arbitration.
- The top level holds the FSM, the claimed mask, the output registers and the optional stats counter.

## Test plan
- Reset then start, with N_ENG=4, all cdones=1 and gen_valid held with 4 words:
  - latch_en must go 0001, 0010, 0100, 1000 on consecutive cycles.
  - gen_ready=0 on the 5th cycle until a cdones bit falls and rises again.
- Done-lag check: after dispatch to engine 2, hold cdones[2]=1 for one extra cycle. Engine 2 must not be re-granted until cdones[2] has been seen 0 and then 1.
- Last word on the 3rd accept:
  - State goes to DRAIN and gen_ready=0.
  - Engines return done at cycles 10, 14 and 20; frame_done must pulse exactly once, at cycle 21.
- Assert creset for one cycle mid-RUN with claimed=0110: all outputs become 0 immediately, and the next frame's first grant goes to engine 0.
- start pulses during RUN and during DRAIN: no state change, and still one frame_done per frame.
- With MANDEL_DISPATCH_STATS_EN defined and one engine busy for 7 cycles while gen_valid=1: stall_cycles=7 at frame_done.
